// File: rtl/sbox_key_loader.sv
// Blowfish S-box write engine: DEPTH x DW RAM, the sequencer that fills it
// from key-schedule (L,R) pairs, and the registered lookup port for the F-function.
module sbox_key_loader #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          pair_valid,
  output logic          pair_ready,
  input  logic [DW-1:0] pair_l,
  input  logic [DW-1:0] pair_r,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCEPT  = 2'd1;
  localparam logic [1:0] ST_WRITE_R = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Address of the final entry; the R write here completes a load.
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_nxt;
  logic [DW-1:0] r_hold;
  logic [DW-1:0] r_hold_nxt;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          xfer;

  // S-box storage; deliberately not reset so contents survive rst_n.
  logic [DW-1:0] mem [0:DEPTH-1];

  // pair_ready is a flop that mirrors state==ACCEPT, so it is safe to use here.
  assign xfer = pair_valid && pair_ready;

  // Next-state, pointer and write-port control.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    r_hold_nxt = r_hold;
    wr_en      = 1'b0;
    wr_data    = pair_l;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_ACCEPT;
          ptr_nxt   = '0;
        end
      end
      ST_ACCEPT: begin
        if (xfer) begin
          wr_en      = 1'b1;
          wr_data    = pair_l;
          r_hold_nxt = pair_r;
          ptr_nxt    = ptr + AW'(1);
          state_nxt  = ST_WRITE_R;
        end
      end
      ST_WRITE_R: begin
        wr_en     = 1'b1;
        wr_data   = r_hold;
        ptr_nxt   = ptr + AW'(1);
        state_nxt = (ptr == LAST_PTR) ? ST_DONE : ST_ACCEPT;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, pointer and held R half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      r_hold <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      r_hold <= r_hold_nxt;
    end
  end

  // Status outputs decoded from the next state so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      pair_ready <= (state_nxt == ST_ACCEPT);
      busy       <= (state_nxt == ST_ACCEPT) || (state_nxt == ST_WRITE_R);
      done       <= (state_nxt == ST_DONE);
    end
  end

  // RAM write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr] <= wr_data;
    end
  end

  // Registered lookup; a same-cycle write to rd_addr returns the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_sbox_key_loader.sv
// Directed/randomized bench for sbox_key_loader with an entry-level memory model.
module tb_sbox_key_loader;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;
  localparam logic [31:0] KA    = 32'hd1320ba6;
  localparam logic [31:0] KB    = 32'h98dfb5ac;
  localparam logic [31:0] OFS   = 32'h0100_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pair_valid = 1'b0;
  logic          pair_ready;
  logic [DW-1:0] pair_l = '0;
  logic [DW-1:0] pair_r = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;

  sbox_key_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pair_valid(pair_valid), .pair_ready(pair_ready),
    .pair_l(pair_l), .pair_r(pair_r),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: entry contents and next entry a pair will land in.
  logic [31:0] exp_mem [DEPTH];
  int          ptr_m = 0;

  // Independent observers: handshakes, done rising edges, clock edges.
  int   hs_seen = 0;
  int   done_rises = 0;
  int   cyc = 0;
  logic done_q = 1'b0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (pair_valid === 1'b1 && pair_ready === 1'b1) hs_seen = hs_seen + 1;
  end
  always @(negedge clk) begin
    if (done === 1'b1 && done_q !== 1'b1) done_rises = done_rises + 1;
    done_q = done;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_pair(input logic [31:0] l, input logic [31:0] r);
    exp_mem[ptr_m] = l;
    exp_mem[(ptr_m + 1) % DEPTH] = r;
    ptr_m = (ptr_m + 2) % DEPTH;
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_pair(input logic [31:0] l, input logic [31:0] r, input int gap);
    int waited;
    pair_valid = 1'b0;
    repeat (gap) @(negedge clk);
    pair_l = l;
    pair_r = r;
    pair_valid = 1'b1;
    waited = 0;
    while (pair_ready !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (pair_ready !== 1'b1) begin
      chk("handshake_timeout", 32'(pair_ready), 32'd1);
      pair_valid = 1'b0;
      return;
    end
    model_pair(l, r);
    @(negedge clk);
    pair_valid = 1'b0;
    chk("ready_low_in_write_r", 32'(pair_ready), 32'd0);
    chk("busy_during_load", 32'(busy), 32'd1);
    chk("done_low_during_load", 32'(done), 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ptr_m = 0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_ready", 32'(pair_ready), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < int'(DEPTH); a++) begin
      rd_addr = AW'(a);
      @(negedge clk);
      chk($sformatf("%s[%0d]", tag, a), rd_data, exp_mem[a]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    int c0;
    int d0;
    logic [31:0] l;
    logic [31:0] r;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(pair_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(pair_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // 1: back-to-back sequential load at full rate
    hs0 = hs_seen;
    do_start();
    c0 = cyc;
    for (int k = 0; k < 128; k++) send_pair(32'(2 * k), 32'(2 * k + 1), 0);
    @(negedge clk);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy_off", 32'(busy), 32'd0);
    chk("t1_ready_off", 32'(pair_ready), 32'd0);
    chk("t1_cycles", 32'(cyc - c0), 32'd256);
    chk("t1_handshakes", 32'(hs_seen - hs0), 32'd128);
    read_all("t1_rd");

    // 5 then 2: read-before-write at entry 0, then gapped constant pairs
    hs0 = hs_seen;
    do_start();
    rd_addr = '0;
    send_pair(KA, KB, 0);
    chk("t5_old_on_write", rd_data, 32'h0);
    @(negedge clk);
    chk("t5_new_next", rd_data, KA);
    for (int k = 1; k < 128; k++) send_pair(KA, KB, int'($urandom_range(0, 5)));
    wait_done("t2_done");
    chk("t2_handshakes", 32'(hs_seen - hs0), 32'd128);
    read_all("t2_rd");

    // 3: valid held high, data changing every cycle
    hs0 = hs_seen;
    do_start();
    for (int i = 0; i < 256; i++) begin
      chk("t3_ready_pattern", 32'(pair_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      l = $urandom;
      r = $urandom;
      pair_l = l;
      pair_r = r;
      pair_valid = 1'b1;
      if (i % 2 == 0) model_pair(l, r);
      @(negedge clk);
    end
    pair_valid = 1'b0;
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_handshakes", 32'(hs_seen - hs0), 32'd128);
    read_all("t3_rd");

    // 4: start pulsed mid-load is ignored
    d0 = done_rises;
    do_start();
    for (int k = 0; k < 10; k++) send_pair(OFS | 32'(2 * k), OFS | 32'(2 * k + 1), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4_busy_after_start", 32'(busy), 32'd1);
    for (int k = 10; k < 128; k++) send_pair(OFS | 32'(2 * k), OFS | 32'(2 * k + 1), 0);
    wait_done("t4_done");
    repeat (4) @(negedge clk);
    chk("t4_done_once", 32'(done_rises - d0), 32'd1);
    read_all("t4_rd");

    // 6: reset after 50 pairs, then a full reload
    do_start();
    for (int k = 0; k < 50; k++) send_pair($urandom, $urandom, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(pair_ready), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_rd_data", rd_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    @(negedge clk);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_idle_done", 32'(done), 32'd0);
    read_all("t6_partial");
    do_start();
    for (int k = 0; k < 128; k++) send_pair($urandom, $urandom, int'($urandom_range(0, 2)));
    wait_done("t6_done");
    read_all("t6_reload");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
